// File: rtl/clk_gen_tuner.sv
// Calibration controller for the tunable clock generator: counts osc edges
// over a reference window and SAR-searches the slowest select meeting target.
module clk_gen_tuner #(
    parameter int CNT_WIDTH     = 16,
    parameter int SEL_WIDTH     = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] target_i,
    input  logic [CNT_WIDTH-1:0] window_i,
    input  logic                 osc_clk_i,
    output logic [SEL_WIDTH-1:0] select_o,
    output logic                 osc_reset_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 locked_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DECIDE,
        S_DONE
    } state_t;

    localparam logic [SEL_WIDTH-1:0] MSB_MASK =
        {1'b1, {(SEL_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD =
        CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_WIDTH-1:0]   edges_q;
    logic [CNT_WIDTH-1:0]   timer_q;
    logic [CNT_WIDTH-1:0]   target_q;
    logic [CNT_WIDTH-1:0]   window_q;
    logic [SEL_WIDTH-1:0]   result_q;
    logic [SEL_WIDTH-1:0]   mask_q;
    logic [SEL_WIDTH-1:0]   select_q;
    logic                   osc_reset_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   locked_q;
    logic [CNT_WIDTH-1:0]   count_q;

    logic                   rise_d;
    logic                   pass_d;
    logic [SEL_WIDTH-1:0]   result_d;
    logic [CNT_WIDTH-1:0]   window_d;

    always_comb begin
        rise_d   = sync_q[SYNC_STAGES-1] & ~prev_q;
        pass_d   = (edges_q >= target_q);
        result_d = pass_d ? (result_q | mask_q) : result_q;
        window_d = (window_i == '0) ? CNT_ONE : window_i;
    end

    // mask_q walks MSB..LSB over the trial passes; zero means verify pass
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            prev_q      <= 1'b0;
            edges_q     <= '0;
            timer_q     <= '0;
            target_q    <= '0;
            window_q    <= '0;
            result_q    <= '0;
            mask_q      <= '0;
            select_q    <= '0;
            osc_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            locked_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_clk_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        target_q    <= target_i;
                        window_q    <= window_d;
                        result_q    <= '0;
                        mask_q      <= MSB_MASK;
                        select_q    <= MSB_MASK;
                        osc_reset_q <= 1'b0;
                        busy_q      <= 1'b1;
                        locked_q    <= 1'b0;
                        count_q     <= '0;
                        edges_q     <= '0;
                        timer_q     <= SETTLE_LOAD;
                        state_q     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    edges_q <= '0;
                    if (timer_q == '0) begin
                        timer_q <= window_q - CNT_ONE;
                        state_q <= S_MEASURE;
                    end else begin
                        timer_q <= timer_q - CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    if (rise_d && (edges_q != '1))
                        edges_q <= edges_q + CNT_ONE;
                    if (timer_q == '0)
                        state_q <= S_DECIDE;
                    else
                        timer_q <= timer_q - CNT_ONE;
                end
                S_DECIDE: begin
                    edges_q <= '0;
                    if (mask_q != '0) begin
                        result_q <= result_d;
                        mask_q   <= mask_q >> 1;
                        select_q <= result_d | (mask_q >> 1);
                        timer_q  <= SETTLE_LOAD;
                        state_q  <= S_SETTLE;
                    end else begin
                        count_q  <= edges_q;
                        locked_q <= pass_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign select_o    = select_q;
    assign osc_reset_o = osc_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign locked_o    = locked_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_clk_gen_tuner.sv
// Bench for clk_gen_tuner with a behavioural oscillator of period
// (4+select) reference cycles and a threshold model of the search.
module tb_clk_gen_tuner;

    localparam int S = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] target;
    logic [15:0] window;
    logic        osc;
    logic [3:0]  select;
    logic        osc_reset;
    logic        busy;
    logic        done;
    logic        locked;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    clk_gen_tuner dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .start_i    (start),
        .target_i   (target),
        .window_i   (window),
        .osc_clk_i  (osc),
        .select_o   (select),
        .osc_reset_o(osc_reset),
        .busy_o     (busy),
        .done_o     (done),
        .locked_o   (locked),
        .count_o    (count)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator steps in half reference periods, offset so its edges
    // never coincide with clk edges; half period = (4+select) steps.
    int ph = 0;
    initial begin
        osc = 1'b0;
        #($urandom_range(1, 9));
        forever begin
            #10;
            if (osc_reset) begin
                osc = 1'b0;
                ph  = 0;
            end else begin
                ph = ph + 1;
                if (ph >= 4 + int'(select)) begin
                    osc = ~osc;
                    ph  = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic run_cal(input int w, input int tg, output int lat);
        int t0;
        @(negedge clk);
        window = 16'(w);
        target = 16'(tg);
        start  = 1'b1;
        t0     = cyc;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int k = 0; k < 20000; k++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL run_timeout: got no done expected done_o pulse");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_select"}, int'(select), 0);
        chk({tag, "_osc_reset"}, int'(osc_reset), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_count"}, int'(count), 0);
    endtask

    typedef struct {
        int w;
        int tg;
        int sel;
        int lock;
        int clo;
        int chi;
    } vec_t;

    vec_t vecs[4];

    function automatic int exp_lat(input int w);
        int we;
        we = (w == 0) ? 1 : w;
        return 1 + 5 * (S + we + 1);
    endfunction

    initial begin
        int lat;
        int t0;
        int bad_busy;
        int bad_done;
        int s5_sel;
        int s5_lock;
        int s5_cnt;
        int w;
        int tg;
        int esel;
        int elock;
        bit ok;
        real ideal;

        vecs[0] = '{600, 52, 7, 1, 54, 55};
        vecs[1] = '{600, 200, 0, 0, 149, 151};
        vecs[2] = '{600, 10, 15, 1, 30, 32};
        vecs[3] = '{0, 0, 15, 1, 0, 1};

        reset_n = 1'b0;
        start   = 1'b0;
        target  = '0;
        window  = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_cal(vecs[i].w, vecs[i].tg, lat);
            chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].w));
            chk($sformatf("v%0d_select", i), int'(select), vecs[i].sel);
            chk($sformatf("v%0d_locked", i), int'(locked), vecs[i].lock);
            chk_rng($sformatf("v%0d_count", i), int'(count),
                    vecs[i].clo, vecs[i].chi);
            repeat (3) @(negedge clk);
        end

        // exact busy/done timing, second start while busy is ignored
        @(negedge clk);
        window   = 16'd600;
        target   = 16'd52;
        start    = 1'b1;
        t0       = cyc;
        bad_busy = 0;
        bad_done = 0;
        s5_sel   = -1;
        s5_lock  = -1;
        s5_cnt   = -1;
        for (int k = 1; k <= 3040; k++) begin
            @(negedge clk);
            start = (k == 99);
            if (int'(busy) != int'(k >= 1 && k <= 3025))
                bad_busy = bad_busy + 1;
            if (int'(done) != int'(k == 3026))
                bad_done = bad_done + 1;
            if (k == 3026) begin
                s5_sel  = int'(select);
                s5_lock = int'(locked);
                s5_cnt  = int'(count);
            end
        end
        chk("t5_busy_bad_cycles", bad_busy, 0);
        chk("t5_done_bad_cycles", bad_done, 0);
        chk("t5_select", s5_sel, 7);
        chk("t5_locked", s5_lock, 1);
        chk_rng("t5_count", s5_cnt, 54, 55);
        chk("t5_select_held", int'(select), 7);

        // reset during pass 3 aborts, then the run is repeatable
        @(negedge clk);
        window = 16'd600;
        target = 16'd52;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1300) @(negedge clk);
        chk("t6_busy_before_reset", int'(busy), 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_reset_vals("t6_reset");
        run_cal(600, 52, lat);
        chk("t6_latency", lat, 3026);
        chk("t6_select", int'(select), 7);
        chk("t6_locked", int'(locked), 1);
        chk_rng("t6_count", int'(count), 54, 55);

        // random windows/targets against the threshold model
        for (int r = 0; r < 8; r++) begin
            w  = int'($urandom_range(100, 600));
            tg = 0;
            for (int tr = 0; tr < 200; tr++) begin
                tg = int'($urandom_range(1, w / 4 + 10));
                ok = 1'b1;
                for (int s = 0; s < 16; s++) begin
                    ideal = real'(w) / real'(4 + s);
                    if (ideal - real'(tg) < 2.5 && real'(tg) - ideal < 2.5)
                        ok = 1'b0;
                end
                if (ok) break;
                tg = 0;
            end
            esel  = 0;
            elock = 0;
            for (int s = 15; s >= 0; s--) begin
                if (real'(w) / real'(4 + s) >= real'(tg)) begin
                    esel  = s;
                    elock = 1;
                    break;
                end
            end
            run_cal(w, tg, lat);
            chk($sformatf("r%0d_latency w=%0d", r, w), lat, exp_lat(w));
            chk($sformatf("r%0d_select w=%0d t=%0d", r, w, tg),
                int'(select), esel);
            chk($sformatf("r%0d_locked w=%0d t=%0d", r, w, tg),
                int'(locked), elock);
            ideal = real'(w) / real'(4 + esel);
            chk_rng($sformatf("r%0d_count w=%0d sel=%0d", r, w, esel),
                    int'(count), int'($floor(ideal - 2.0)),
                    int'($ceil(ideal + 2.0)));
            repeat (2) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
